// File: rtl/phy_lane_arbiter.sv
// Four-lane round-robin byte scheduler onto one PHY transmit channel; each lane has a private FIFO.
// One edge of latency from grant to the registered output; out_ready=0 freezes the grant, pops and outputs.
module phy_lane_arbiter #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_SYMBOL = 8'hBC
) (
  input  logic                  clk_4f,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic                  valid_in_0,
  input  logic                  valid_in_1,
  input  logic                  valid_in_2,
  input  logic                  valid_in_3,
  output logic                  full_0,
  output logic                  full_1,
  output logic                  full_2,
  output logic                  full_3,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            lane_out,
  output logic [3:0]            overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [4][FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr [4];
  logic [AW-1:0]         rd_ptr [4];
  logic [CW-1:0]         count [4];
  logic [DATA_WIDTH-1:0] din [4];
  logic [3:0]            vin;
  logic [3:0]            full;
  logic [3:0]            push;
  logic [3:0]            pop;
  logic [1:0]            ptr;
  logic [1:0]            grant;
  logic [1:0]            idx;
  logic                  grant_vld;

  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign din[2] = data_in_2;
  assign din[3] = data_in_3;
  assign vin    = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};
  assign full_0 = full[0];
  assign full_1 = full[1];
  assign full_2 = full[2];
  assign full_3 = full[3];

  // Scan from ptr; counts are pre-edge, so a byte pushed this edge is not yet eligible.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!grant_vld && count[idx] != '0) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  always_comb begin
    full = '0;
    push = '0;
    pop  = '0;
    for (int i = 0; i < 4; i++) begin
      full[i] = (count[i] == CW'(FIFO_DEPTH));
      push[i] = vin[i] && !full[i];
      pop[i]  = out_ready && grant_vld && (grant == 2'(i));
    end
  end

  always_ff @(posedge clk_4f) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= din[i];
    end
  end

  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      for (int i = 0; i < 4; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      ptr       <= '0;
      data_out  <= IDLE_SYMBOL;
      valid_out <= 1'b0;
      lane_out  <= '0;
      overflow  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
        if (vin[i] && full[i]) overflow[i] <= 1'b1;
      end
      if (out_ready) begin
        if (grant_vld) begin
          data_out  <= mem[grant][rd_ptr[grant]];
          valid_out <= 1'b1;
          lane_out  <= grant;
          ptr       <= grant + 2'd1;
        end else begin
          data_out  <= IDLE_SYMBOL;
          valid_out <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_phy_lane_arbiter.sv
// Bench for phy_lane_arbiter: directed scenarios then randomized traffic against a queue-based model.
module tb_phy_lane_arbiter;
  localparam int DEPTH = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk_4f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic       valid_in_0, valid_in_1, valid_in_2, valid_in_3;
  logic       full_0, full_1, full_2, full_3;
  logic       out_ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic [3:0] overflow;

  always #5 clk_4f = ~clk_4f;

  phy_lane_arbiter #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .IDLE_SYMBOL(IDLE)) dut (
    .clk_4f(clk_4f), .reset_L(reset_L),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .valid_in_0(valid_in_0), .valid_in_1(valid_in_1), .valid_in_2(valid_in_2), .valid_in_3(valid_in_3),
    .full_0(full_0), .full_1(full_1), .full_2(full_2), .full_3(full_3),
    .out_ready(out_ready), .data_out(data_out), .valid_out(valid_out),
    .lane_out(lane_out), .overflow(overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q [4][$];
  int         m_ptr;
  logic [7:0] exp_data;
  logic       exp_vld;
  logic [1:0] exp_lane;
  logic [3:0] exp_ovf;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic [3:0] v, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                       input logic rdy);
    reset_L = rst_n; out_ready = rdy;
    {valid_in_3, valid_in_2, valid_in_1, valid_in_0} = v;
    data_in_0 = d0; data_in_1 = d1; data_in_2 = d2; data_in_3 = d3;
  endtask

  // Reference: pop from pre-edge queue state, then apply writes judged against pre-edge fullness.
  task automatic model_edge();
    logic [3:0] v;
    logic [7:0] d [4];
    bit         was_full [4];
    int         g;
    v = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};
    d[0] = data_in_0; d[1] = data_in_1; d[2] = data_in_2; d[3] = data_in_3;
    if (!reset_L) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      m_ptr = 0; exp_data = IDLE; exp_vld = 1'b0; exp_lane = 2'd0; exp_ovf = 4'b0;
      return;
    end
    for (int i = 0; i < 4; i++) was_full[i] = (q[i].size() == DEPTH);
    if (out_ready) begin
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && q[(m_ptr + k) % 4].size() > 0) g = (m_ptr + k) % 4;
      if (g >= 0) begin
        exp_data = q[g].pop_front();
        exp_vld  = 1'b1;
        exp_lane = 2'(g);
        m_ptr    = (g + 1) % 4;
      end else begin
        exp_data = IDLE;
        exp_vld  = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        if (was_full[i]) exp_ovf[i] = 1'b1;
        else q[i].push_back(d[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_4f);
    model_edge();
    #1;
    chk("data_out", data_out, exp_data);
    chk("valid_out", {7'b0, valid_out}, {7'b0, exp_vld});
    chk("lane_out", {6'b0, lane_out}, {6'b0, exp_lane});
    chk("overflow", {4'b0, overflow}, {4'b0, exp_ovf});
    chk("full", {4'b0, full_3, full_2, full_1, full_0},
        {4'b0, 1'(q[3].size() == DEPTH), 1'(q[2].size() == DEPTH),
         1'(q[1].size() == DEPTH), 1'(q[0].size() == DEPTH)});
  endtask

  initial begin
    m_ptr = 0; exp_data = IDLE; exp_vld = 0; exp_lane = 0; exp_ovf = 0;

    // Reset held two edges while every lane strobes a write
    drive(1'b0, 4'hF, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
    tick(); tick();
    chk("rst_data", data_out, 8'hBC);
    chk("rst_vld", {7'b0, valid_out}, 8'h00);
    chk("rst_ovf", {4'b0, overflow}, 8'h00);
    drive(1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    chk("rst_nostore", {7'b0, valid_out}, 8'h00);

    // Fairness: one write edge on all lanes, then four grants in lane order
    drive(1'b1, 4'hF, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 1'b1);
    tick();
    chk("fair_latency", {7'b0, valid_out}, 8'h00);
    drive(1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tick(); chk("fair0", data_out, 8'hFF); chk("fair0_lane", {6'b0, lane_out}, 8'd0);
    tick(); chk("fair1", data_out, 8'hEE); chk("fair1_lane", {6'b0, lane_out}, 8'd1);
    tick(); chk("fair2", data_out, 8'hDD); chk("fair2_lane", {6'b0, lane_out}, 8'd2);
    tick(); chk("fair3", data_out, 8'hCC); chk("fair3_lane", {6'b0, lane_out}, 8'd3);
    tick(); chk("fair_idle", data_out, 8'hBC); chk("fair_idle_vld", {7'b0, valid_out}, 8'h00);

    // Skip empty lanes; a following lane0+lane3 write exposes ptr having returned to 0
    drive(1'b1, 4'b1010, 8'h00, 8'hAA, 8'h00, 8'h88, 1'b1);
    tick();
    drive(1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tick(); chk("skip1", data_out, 8'hAA); chk("skip1_lane", {6'b0, lane_out}, 8'd1);
    tick(); chk("skip3", data_out, 8'h88); chk("skip3_lane", {6'b0, lane_out}, 8'd3);
    drive(1'b1, 4'b1001, 8'h5A, 8'h00, 8'h00, 8'hA5, 1'b1);
    tick();
    drive(1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tick(); chk("ptr0_lane", {6'b0, lane_out}, 8'd0);
    tick(); chk("ptr0_next", data_out, 8'hA5);
    tick();

    // Fill lane 2 under backpressure; fifth byte is dropped
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'b0100, 8'h00, 8'h00, 8'(8'h11 * i), 8'h00, 1'b0);
      tick();
      if (i == 4) chk("full2_after4", {7'b0, full_2}, 8'h01);
    end
    chk("ovf_lane2", {4'b0, overflow}, 8'h04);
    drive(1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain2", data_out, 8'(8'h11 * i));
      chk("drain2_lane", {6'b0, lane_out}, 8'd2);
    end
    tick(); chk("drain2_idle", {7'b0, valid_out}, 8'h00);

    // Backpressure hold with a second byte still queued on lane 0
    drive(1'b1, 4'b0001, 8'h15, 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    drive(1'b1, 4'b0001, 8'h16, 8'h00, 8'h00, 8'h00, 1'b1);
    tick(); chk("bp_first", data_out, 8'h15);
    drive(1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("bp_hold", data_out, 8'h15); chk("bp_hold_vld", {7'b0, valid_out}, 8'h01);
    end
    drive(1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tick(); chk("bp_release", data_out, 8'h16);
    tick();

    // Mid-stream reset discards three bytes per lane
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hF, 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i), 8'(8'h50 + i), 1'b0);
      tick();
    end
    drive(1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    drive(1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("mid_rst_idle", {7'b0, valid_out}, 8'h00);
    end

    // Randomized traffic; readiness bias varies per phase to exercise both full and drained regimes
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 500; c++) begin
        drive(($urandom_range(0, 299) != 0), 4'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 5) < ph + 1));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/phy_lane_arbiter.md
Name: phy_lane_arbiter

Overview:
Round-robin scheduler that shares the single byte-wide PHY transmit channel between the four lane inputs (lanes 0-3). Each lane writes into a small private FIFO. Each clk_4f cycle, the arbiter grants one non-empty lane, pops one byte and presents it with its lane tag to the serializer stage. When no lane has data, the idle symbol is driven with valid low.

Parameters:
DATA_WIDTH, 8, byte width of each lane and of the output channel
FIFO_DEPTH, 4, entries per lane FIFO (power of two, >= 2)
IDLE_SYMBOL, 8'hBC, value driven on data_out when no byte is granted

Ports:
clk_4f  input  1  single clock; all state updates on rising edge
reset_L  input  1  synchronous active-low reset, sampled on rising clk_4f
data_in_0..data_in_3  input  DATA_WIDTH each  lane write data
valid_in_0..valid_in_3  input  1 each  lane write strobe
full_0..full_3  output  1 each  lane FIFO full (combinational from count)
out_ready  input  1  downstream serializer can accept a byte this cycle
data_out  output  DATA_WIDTH  granted byte, registered
valid_out  output  1  data_out holds a real byte, registered
lane_out  output  2  lane index of data_out, registered
overflow  output  4  sticky per-lane flag: write attempted while full

Behaviour:
- Single clock clk_4f; reset is synchronous and active-low on reset_L.
- Reset (reset_L=0 at the edge):
  - all FIFOs empty; all counts 0.
  - priority pointer ptr=0.
  - data_out=IDLE_SYMBOL, valid_out=0, lane_out=0, overflow=4'b0000.
  - full_i=0 follows from the counts.
  - Reset mid-operation discards all buffered bytes. No output appears for them.
- Lane write: at an edge with valid_in_i=1 and full_i=0, push data_in_i and increment count_i.
  - valid_in_i=1 with full_i=1: byte is dropped and overflow[i] sets.
  - overflow[i] stays set until reset.
- full_i = (count_i == FIFO_DEPTH). A pop in the same cycle does not unblock a write: full is evaluated before the edge.
- Arbitration is evaluated each edge when out_ready=1:
  - Candidate order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first lane with count>0 is granted (g).
  - Head of FIFO g is popped. data_out<=head, valid_out<=1, lane_out<=g, ptr<=(g+1) mod 4.
  - No lane non-empty: data_out<=IDLE_SYMBOL, valid_out<=0, lane_out and ptr unchanged.
- out_ready=0: no pop; data_out, valid_out, lane_out and ptr hold their values.
- Push and pop on the same lane in the same edge: both occur and the count is unchanged.
  - An empty FIFO written at edge N is not eligible until edge N+1.
- Latency: a byte written at edge N appears on data_out after edge N+1 at the earliest, given out_ready=1 and no competing lanes.
- Throughput: at most one byte per cycle. Each lane gets at least 1 of every 4 grants while it stays non-empty.
- Pointers wrap modulo FIFO_DEPTH; counts range 0..FIFO_DEPTH and never wrap.
- Per-lane byte order is preserved. Order across lanes follows the grant sequence only.

Test Plan:
- Reset check: hold reset_L=0 for 2 edges with valid_in_*=1 -> data_out=8'hBC, valid_out=0, lane_out=0, overflow=0, full_*=0; no bytes stored.
- Round-robin fairness:
  - Stimulus: one edge writes lane0=FF, lane1=EE, lane2=DD, lane3=CC; out_ready=1.
  - Required: the next 4 cycles give (FF,0), (EE,1), (DD,2), (CC,3), then 8'hBC with valid_out=0.
- Skip empty lanes: only lanes 1 and 3 written (AA, 88), ptr=0 -> grants lane1 then lane3; ptr ends at 0.
- Full/overflow:
  - Stimulus: out_ready=0; write lane2 five consecutive edges (11,22,33,44,55).
  - Required: full_2=1 after the 4th write; 55 dropped; overflow=4'b0100.
  - Then out_ready=1 yields 11,22,33,44 in order, all on lane 2.
- Backpressure hold: valid_out=1 with data 15 on lane0, then out_ready=0 for 3 cycles -> outputs unchanged and counts unchanged.
- Mid-stream reset: lanes hold 3 bytes each, then reset_L=0 for 1 edge -> idle output, counts 0, and no stale bytes after reset is released.
